cam_pixel_capture: RTL and testbench

CAM_PIXEL_CAPTURE -- requirements
Module: cam_pixel_capture

---
 rtl/cam_pkg.sv | 16 +
 rtl/cam_pixel_capture_if.sv | 23 ++
 rtl/cam_sync_edge.sv | 42 ++++
 rtl/cam_pixel_capture.sv | 124 ++++++++++++
 tb/tb_cam_pixel_capture.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera pixel-capture block.
package cam_pkg;

  localparam int unsigned H_BYTES_DEF = 1280;
  localparam int unsigned V_LINES_DEF = 480;
  localparam int unsigned PIX_W       = 11;
  localparam int unsigned LINE_W      = 10;
  localparam int unsigned FRAME_W     = 3;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    VBLANK    = 2'd1,
    ACTIVE    = 2'd2
  } cam_state_e;

endpackage

// File: rtl/cam_pixel_capture_if.sv
// Camera byte bus in, assembled pixel bus out.
interface cam_pixel_capture_if;
  import cam_pkg::*;

  logic              CamVsync;
  logic              CamHsync;
  logic [7:0]        CamData_in;
  logic [15:0]       CamData_out;
  logic              CamData_enable;
  logic [PIX_W-1:0]  CamPix_count;
  logic [LINE_W-1:0] CamHsync_count;

  modport master (
    output CamVsync, CamHsync, CamData_in,
    input  CamData_out, CamData_enable, CamPix_count, CamHsync_count
  );

  modport slave (
    input  CamVsync, CamHsync, CamData_in,
    output CamData_out, CamData_enable, CamPix_count, CamHsync_count
  );

endinterface

// File: rtl/cam_sync_edge.sv
// Input register stage for the camera bus plus vsync/hsync edge detection.
module cam_sync_edge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync_i,
  input  logic       hsync_i,
  input  logic [7:0] data_i,
  output logic       vsync_q_o,
  output logic       hsync_q_o,
  output logic [7:0] data_q_o,
  output logic       vsync_rise_o,
  output logic       vsync_fall_o,
  output logic       hsync_fall_o
);

  logic       vsync_q, hsync_q, vsync_qq, hsync_qq;
  logic [7:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q  <= 1'b0;
      hsync_q  <= 1'b0;
      data_q   <= '0;
      vsync_qq <= 1'b0;
      hsync_qq <= 1'b0;
    end else begin
      vsync_q  <= vsync_i;
      hsync_q  <= hsync_i;
      data_q   <= data_i;
      vsync_qq <= vsync_q;
      hsync_qq <= hsync_q;
    end
  end

  assign vsync_q_o    = vsync_q;
  assign hsync_q_o    = hsync_q;
  assign data_q_o     = data_q;
  assign vsync_rise_o = vsync_q & ~vsync_qq;
  assign vsync_fall_o = ~vsync_q & vsync_qq;
  assign hsync_fall_o = ~hsync_q & hsync_qq;

endmodule

// File: rtl/cam_pixel_capture.sv
// Frame/line tracking FSM and RGB565 byte-pair assembly for a parallel camera.
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int unsigned H_BYTES = H_BYTES_DEF,
  parameter int unsigned V_LINES = V_LINES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  cam_pixel_capture_if.slave cam,
  input  logic               capture_en,
  input  logic               err_clr,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count,
  output logic               CamErr
);

  localparam logic [PIX_W-1:0]  H_MAX = PIX_W'(H_BYTES);
  localparam logic [LINE_W-1:0] V_MAX = LINE_W'(V_LINES);

  logic       vsync_q, hsync_q, vsync_rise, vsync_fall, hsync_fall;
  logic [7:0] data_q;

  cam_sync_edge u_sync (
    .clk          (clk),
    .rst_n        (reset),
    .vsync_i      (cam.CamVsync),
    .hsync_i      (cam.CamHsync),
    .data_i       (cam.CamData_in),
    .vsync_q_o    (vsync_q),
    .hsync_q_o    (hsync_q),
    .data_q_o     (data_q),
    .vsync_rise_o (vsync_rise),
    .vsync_fall_o (vsync_fall),
    .hsync_fall_o (hsync_fall)
  );

  cam_state_e         state_q;
  logic               phase_q, cap_frame_q, enable_q, frame_start_q, err_q, err_d;
  logic [7:0]         hi_q;
  logic [15:0]        data_out_q;
  logic [PIX_W-1:0]   byte_cnt_q, pix_q;
  logic [LINE_W-1:0]  line_cnt_q;
  logic [FRAME_W-1:0] frame_cnt_q;

  logic active, leave, line_end, byte_ok, over, err_set;

  // Vsync rising in ACTIVE takes priority over any line activity in that cycle.
  always_comb begin
    active   = (state_q == ACTIVE);
    leave    = active & vsync_rise;
    line_end = active & ~vsync_rise & hsync_fall;
    byte_ok  = active & ~vsync_rise & hsync_q;
    over     = (byte_cnt_q >= H_MAX) | (line_cnt_q >= V_MAX);
    err_set  = (byte_ok & over) | (line_end & phase_q) | (leave & (line_cnt_q != V_MAX));
    err_d    = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SYNC_WAIT;
      phase_q       <= 1'b0;
      cap_frame_q   <= 1'b0;
      enable_q      <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
      hi_q          <= '0;
      data_out_q    <= '0;
      byte_cnt_q    <= '0;
      pix_q         <= '0;
      line_cnt_q    <= '0;
      frame_cnt_q   <= '0;
    end else begin
      frame_start_q <= 1'b0;
      enable_q      <= 1'b0;
      err_q         <= err_d;
      case (state_q)
        SYNC_WAIT: begin
          if (vsync_q) state_q <= VBLANK;
        end
        VBLANK: begin
          if (vsync_fall) begin
            state_q       <= ACTIVE;
            frame_start_q <= 1'b1;
            line_cnt_q    <= '0;
            byte_cnt_q    <= '0;
            phase_q       <= 1'b0;
            cap_frame_q   <= capture_en;
          end
        end
        ACTIVE: begin
          if (vsync_rise) begin
            state_q     <= VBLANK;
            frame_cnt_q <= frame_cnt_q + 1'b1;
          end else if (hsync_fall) begin
            line_cnt_q <= (line_cnt_q < V_MAX) ? line_cnt_q + 1'b1 : V_MAX;
            byte_cnt_q <= '0;
            phase_q    <= 1'b0;
          end else if (hsync_q) begin
            phase_q    <= ~phase_q;
            byte_cnt_q <= (byte_cnt_q < H_MAX) ? byte_cnt_q + 1'b1 : H_MAX;
            if (!phase_q) begin
              hi_q <= data_q;
            end else if (cap_frame_q && !over) begin
              data_out_q <= {hi_q, data_q};
              pix_q      <= byte_cnt_q - 1'b1;
              enable_q   <= 1'b1;
            end
          end
        end
        default: state_q <= SYNC_WAIT;
      endcase
    end
  end

  assign cam.CamData_out    = data_out_q;
  assign cam.CamData_enable = enable_q;
  assign cam.CamPix_count   = pix_q;
  assign cam.CamHsync_count = line_cnt_q;
  assign frame_start        = frame_start_q;
  assign frame_count        = frame_cnt_q;
  assign CamErr             = err_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench for cam_pixel_capture on a reduced 8-byte x 4-line frame.
module tb_cam_pixel_capture;
  import cam_pkg::*;

  localparam int unsigned HB = 8;
  localparam int unsigned VL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic capture_en = 1'b0;
  logic err_clr = 1'b0;
  logic frame_start;
  logic [FRAME_W-1:0] frame_count;
  logic CamErr;

  always #5 clk = ~clk;

  cam_pixel_capture_if cam_if ();

  cam_pixel_capture #(.H_BYTES(HB), .V_LINES(VL)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .cam         (cam_if),
    .capture_en  (capture_en),
    .err_clr     (err_clr),
    .frame_start (frame_start),
    .frame_count (frame_count),
    .CamErr      (CamErr)
  );

  typedef struct {
    logic [15:0] data;
    int          pix;
    int          line;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int n_strobe = 0;
  int n_fs = 0;
  int last_pix = -1;
  int last_line = -1;
  int cur_line = 0;
  int s0;
  logic tb_cap = 1'b0;
  logic [7:0] prev = '0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  function automatic logic [7:0] pat(input int line, input int i);
    return 8'(line * 49 + i * 7 + 5);
  endfunction

  task automatic push(input logic [15:0] d, input int pix, input int line);
    exp_t e;
    e.data = d;
    e.pix  = pix;
    e.line = line;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && cam_if.CamData_enable) begin
      n_strobe++;
      last_pix  = int'(cam_if.CamPix_count);
      last_line = int'(cam_if.CamHsync_count);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pix_data", int'(cam_if.CamData_out), int'(mon_e.data));
        chk("pix_count", int'(cam_if.CamPix_count), mon_e.pix);
        chk("line_count", int'(cam_if.CamHsync_count), mon_e.line);
      end
    end
    if (rst_n && frame_start) n_fs++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame(input logic cap);
    capture_en = cap;
    tb_cap = cap;
    cam_if.CamVsync = 1'b1;
    idle(3);
    cam_if.CamVsync = 1'b0;
    idle(3);
    cur_line = 0;
  endtask

  task automatic end_frame();
    cam_if.CamVsync = 1'b1;
    idle(3);
  endtask

  task automatic send_line(input int nbytes, input logic clr_hold);
    logic [7:0] d;
    for (int i = 0; i < nbytes; i++) begin
      d = pat(cur_line, i);
      cam_if.CamHsync = 1'b1;
      cam_if.CamData_in = d;
      err_clr = clr_hold;
      if ((i % 2 == 1) && (i < int'(HB)) && (cur_line < int'(VL)) && tb_cap)
        push({prev, d}, i - 1, cur_line);
      prev = d;
      @(negedge clk);
    end
    cam_if.CamHsync = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    cur_line++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    cam_if.CamVsync   = 1'b1;
    cam_if.CamHsync   = 1'b0;
    cam_if.CamData_in = '0;
    idle(2);
    chk("rst_data_out", int'(cam_if.CamData_out), 0);
    chk("rst_enable", int'(cam_if.CamData_enable), 0);
    chk("rst_pix", int'(cam_if.CamPix_count), 0);
    chk("rst_line", int'(cam_if.CamHsync_count), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    chk("rst_err", int'(CamErr), 0);
    rst_n = 1'b1;
    idle(2);

    // single pixel 0x12,0x34 with latency check
    start_frame(1'b1);
    cam_if.CamHsync = 1'b1;
    cam_if.CamData_in = 8'h12;
    @(negedge clk);
    cam_if.CamData_in = 8'h34;
    push(16'h1234, 0, 0);
    @(negedge clk);
    chk("latency_edge1", int'(cam_if.CamData_enable), 0);
    cam_if.CamHsync = 1'b0;
    @(negedge clk);
    chk("latency_edge2", int'(cam_if.CamData_enable), 1);
    idle(2);
    end_frame();
    chk("short_frame_err", int'(CamErr), 1);
    chk("frame_count_1", int'(frame_count), 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("err_clr_1", int'(CamErr), 0);

    // full captured frame
    s0 = n_strobe;
    start_frame(1'b1);
    for (int l = 0; l < int'(VL); l++) send_line(HB, 1'b0);
    end_frame();
    chk("full_strobes", n_strobe - s0, 16);
    chk("full_last_pix", last_pix, 6);
    chk("full_last_line", last_line, 3);
    chk("frame_count_2", int'(frame_count), 2);
    chk("full_err", int'(CamErr), 0);

    // capture request raised after frame start
    s0 = n_strobe;
    start_frame(1'b0);
    send_line(HB, 1'b0);
    capture_en = 1'b1;
    for (int l = 1; l < int'(VL); l++) send_line(HB, 1'b0);
    end_frame();
    chk("nocap_strobes", n_strobe - s0, 0);
    chk("frame_count_3", int'(frame_count), 3);
    chk("nocap_err", int'(CamErr), 0);

    // overlong lines, err_clr, set-wins-over-clear
    s0 = n_strobe;
    start_frame(1'b1);
    send_line(HB + 1, 1'b0);
    chk("long_line_err", int'(CamErr), 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("err_clr_2", int'(CamErr), 0);
    send_line(HB + 4, 1'b1);
    chk("err_set_wins", int'(CamErr), 1);
    send_line(HB, 1'b0);
    send_line(HB, 1'b0);
    end_frame();
    chk("long_strobes", n_strobe - s0, 16);
    chk("frame_count_4", int'(frame_count), 4);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("err_clr_3", int'(CamErr), 0);

    // vsync rises mid-line
    s0 = n_strobe;
    start_frame(1'b1);
    send_line(HB, 1'b0);
    for (int i = 0; i < int'(HB); i++) begin
      d = pat(1, i);
      cam_if.CamHsync = 1'b1;
      cam_if.CamData_in = d;
      if (i == 4) cam_if.CamVsync = 1'b1;
      if ((i % 2 == 1) && (i < 4)) push({prev, d}, i - 1, 1);
      prev = d;
      @(negedge clk);
    end
    cam_if.CamHsync = 1'b0;
    idle(3);
    chk("midline_strobes", n_strobe - s0, 6);
    chk("midline_err", int'(CamErr), 1);
    chk("frame_count_5", int'(frame_count), 5);

    // asynchronous reset mid-line, released with vsync low
    start_frame(1'b1);
    send_line(HB, 1'b0);
    for (int i = 0; i < 6; i++) begin
      d = pat(1, i);
      cam_if.CamHsync = 1'b1;
      cam_if.CamData_in = d;
      if (i == 1 || i == 3) push({prev, d}, i - 1, 1);
      prev = d;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_data_out", int'(cam_if.CamData_out), 0);
    chk("async_pix", int'(cam_if.CamPix_count), 0);
    chk("async_line", int'(cam_if.CamHsync_count), 0);
    chk("async_frame_count", int'(frame_count), 0);
    chk("async_err", int'(CamErr), 0);
    chk("queue_at_reset", exp_q.size(), 0);
    cam_if.CamHsync = 1'b0;
    idle(3);
    rst_n = 1'b1;
    s0 = n_strobe;
    tb_cap = 1'b0;
    cur_line = 0;
    send_line(HB, 1'b0);
    send_line(HB, 1'b0);
    chk("post_reset_no_strobe", n_strobe - s0, 0);
    start_frame(1'b1);
    for (int l = 0; l < int'(VL); l++) send_line(HB, 1'b0);
    end_frame();
    chk("post_reset_strobes", n_strobe - s0, 16);
    chk("post_reset_frame_count", int'(frame_count), 1);
    chk("post_reset_err", int'(CamErr), 0);

    idle(4);
    chk("queue_drained", exp_q.size(), 0);
    chk("total_strobes", n_strobe, 61);
    chk("frame_starts", n_fs, 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
